// File: rtl/alarm_ring.sv
// Alarm sequencer: detects the alarm minute, rings a gated 1 kHz beep, supports stop/snooze
// and auto-timeouts for both ringing and snoozing.
module alarm_ring #(
    parameter int TIME_1S    = 50_000_000,
    parameter int TONE_HALF  = 25_000,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sec_l,
    input  logic [3:0] sec_h,
    input  logic [3:0] min_l,
    input  logic [3:0] min_h,
    input  logic [3:0] hour_l,
    input  logic [3:0] hour_h,
    input  logic [3:0] alarm_min_l,
    input  logic [3:0] alarm_min_h,
    input  logic [3:0] alarm_hour_l,
    input  logic [3:0] alarm_hour_h,
    input  logic [1:0] adjust,
    input  logic       alarm_en,
    input  logic       stop_key,
    input  logic       snooze_key,
    output logic       beep,
    output logic       ringing,
    output logic       snoozing
);

    localparam int PRE_W   = (TIME_1S > 2) ? $clog2(TIME_1S) : 1;
    localparam int TONE_W  = (TONE_HALF > 2) ? $clog2(TONE_HALF) : 1;
    localparam int SEC_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
    localparam int SEC_W   = ($clog2(SEC_MAX + 1) > 9) ? $clog2(SEC_MAX + 1) : 9;

    localparam logic [PRE_W-1:0]  PRE_MAX    = PRE_W'(TIME_1S - 1);
    localparam logic [PRE_W-1:0]  PRE_HALF   = PRE_W'(TIME_1S / 2);
    localparam logic [TONE_W-1:0] TONE_MAX   = TONE_W'(TONE_HALF - 1);
    localparam logic [SEC_W-1:0]  RING_LAST  = SEC_W'(RING_SEC - 1);
    localparam logic [SEC_W-1:0]  SNZ_LAST   = SEC_W'(SNOOZE_SEC - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RING   = 2'd1;
    localparam logic [1:0] SNOOZE = 2'd2;

    logic [1:0]        state, state_nx;
    logic [PRE_W-1:0]  pre_cnt, pre_nx;
    logic [SEC_W-1:0]  sec_cnt, sec_nx;
    logic [TONE_W-1:0] tone_cnt, tone_cnt_nx;
    logic              tone, tone_nx;
    logic              beep_nx;
    logic              match, match_r, match_d, match_rise;
    logic [1:0]        rst_pipe;
    logic              pre_wrap, ring_done, snooze_done, stay_active;

    // The comparator output is registered before edge detection, so ringing
    // follows the time inputs by two cycles.
    assign match = ({hour_h, hour_l, min_h, min_l} ==
                    {alarm_hour_h, alarm_hour_l, alarm_min_h, alarm_min_l}) &&
                   (sec_h == 4'd0) && (sec_l == 4'd0) && (adjust == 2'd0) && alarm_en;

    // rst_pipe masks the edge detector until the match pipeline holds real
    // post-reset samples, so a match held across reset release never fires.
    assign match_rise  = match_r & ~match_d & ~rst_pipe[1];
    assign pre_wrap    = (pre_cnt == PRE_MAX);
    assign ring_done   = pre_wrap && (sec_cnt == RING_LAST);
    assign snooze_done = pre_wrap && (sec_cnt == SNZ_LAST);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (match_rise) state_nx = RING;
            RING: begin
                if (!alarm_en || stop_key) state_nx = IDLE;
                else if (snooze_key)       state_nx = SNOOZE;
                else if (ring_done)        state_nx = IDLE;
            end
            SNOOZE: begin
                if (!alarm_en || stop_key) state_nx = IDLE;
                else if (snooze_done)      state_nx = RING;
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        stay_active = (state_nx == state) && (state != IDLE);
        pre_nx      = '0;
        sec_nx      = '0;
        tone_cnt_nx = '0;
        tone_nx     = 1'b0;
        if (stay_active) begin
            pre_nx = pre_wrap ? '0 : pre_cnt + 1'b1;
            sec_nx = pre_wrap ? sec_cnt + 1'b1 : sec_cnt;
        end
        if (stay_active && (state == RING)) begin
            tone_cnt_nx = (tone_cnt == TONE_MAX) ? '0 : tone_cnt + 1'b1;
            tone_nx     = (tone_cnt == TONE_MAX) ? ~tone : tone;
        end
        // Built from next-cycle values so beep never lingers after leaving RING.
        beep_nx = (state_nx == RING) && tone_nx && (pre_nx < PRE_HALF);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pre_cnt  <= '0;
            sec_cnt  <= '0;
            tone_cnt <= '0;
            tone     <= 1'b0;
            beep     <= 1'b0;
            match_r  <= 1'b0;
            match_d  <= 1'b0;
            rst_pipe <= 2'b11;
        end else begin
            state    <= state_nx;
            pre_cnt  <= pre_nx;
            sec_cnt  <= sec_nx;
            tone_cnt <= tone_cnt_nx;
            tone     <= tone_nx;
            beep     <= beep_nx;
            match_r  <= match;
            match_d  <= match_r;
            rst_pipe <= {rst_pipe[0], 1'b0};
        end
    end

    assign ringing  = (state == RING);
    assign snoozing = (state == SNOOZE);

endmodule

// File: tb/tb_alarm_ring.sv
// Self-checking bench for alarm_ring: directed scenarios plus random traffic,
// compared every cycle against a cycles-in-mode reference model.
module tb_alarm_ring;

    localparam int T  = 10;
    localparam int TH = 2;
    localparam int RS = 4;
    localparam int SS = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sec_l, sec_h, min_l, min_h, hour_l, hour_h;
    logic [3:0] alarm_min_l, alarm_min_h, alarm_hour_l, alarm_hour_h;
    logic [1:0] adjust;
    logic       alarm_en, stop_key, snooze_key;
    logic       beep, ringing, snoozing;

    int checks = 0;
    int errors = 0;

    alarm_ring #(.TIME_1S(T), .TONE_HALF(TH), .RING_SEC(RS), .SNOOZE_SEC(SS)) dut (
        .clk(clk), .rst(rst),
        .sec_l(sec_l), .sec_h(sec_h), .min_l(min_l), .min_h(min_h),
        .hour_l(hour_l), .hour_h(hour_h),
        .alarm_min_l(alarm_min_l), .alarm_min_h(alarm_min_h),
        .alarm_hour_l(alarm_hour_l), .alarm_hour_h(alarm_hour_h),
        .adjust(adjust), .alarm_en(alarm_en), .stop_key(stop_key), .snooze_key(snooze_key),
        .beep(beep), .ringing(ringing), .snoozing(snoozing)
    );

    always #5 clk = ~clk;

    // Decimal view of the inputs; BCD ports are derived from these.
    int t_h, t_m, t_s, a_h, a_m;

    typedef enum {M_IDLE, M_RING, M_SNOOZE} mode_t;
    mode_t m_mode = M_IDLE;
    int    m_age  = 0;          // cycles spent in the current mode
    bit    h1_v = 0, h1_m = 0;  // match sample one edge ago (valid = not in reset)
    bit    h2_v = 0, h2_m = 0;  // match sample two edges ago
    int    ring_cycles = 0;     // length of the most recent ring window

    task automatic apply_time(input int h, input int m, input int s);
        t_h = h; t_m = m; t_s = s;
        hour_h = 4'(h / 10); hour_l = 4'(h % 10);
        min_h  = 4'(m / 10); min_l  = 4'(m % 10);
        sec_h  = 4'(s / 10); sec_l  = 4'(s % 10);
    endtask

    task automatic apply_alarm(input int h, input int m);
        a_h = h; a_m = m;
        alarm_hour_h = 4'(h / 10); alarm_hour_l = 4'(h % 10);
        alarm_min_h  = 4'(m / 10); alarm_min_l  = 4'(m % 10);
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the reference by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        bit    now_m, rise, done;
        mode_t nx;
        now_m = (t_h == a_h) && (t_m == a_m) && (t_s == 0) && (adjust == 0) && alarm_en;
        rise  = h1_v && h2_v && h1_m && !h2_m;
        h2_v = h1_v; h2_m = h1_m;
        h1_v = !rst; h1_m = rst ? 1'b0 : now_m;
        if (rst) begin
            m_mode = M_IDLE; m_age = 0;
            return;
        end
        nx = m_mode;
        case (m_mode)
            M_IDLE: if (rise) nx = M_RING;
            M_RING: begin
                done = (m_age + 1 == RS * T);
                if (!alarm_en || stop_key) nx = M_IDLE;
                else if (snooze_key)       nx = M_SNOOZE;
                else if (done)             nx = M_IDLE;
            end
            M_SNOOZE: begin
                done = (m_age + 1 == SS * T);
                if (!alarm_en || stop_key) nx = M_IDLE;
                else if (done)             nx = M_RING;
            end
            default: nx = M_IDLE;
        endcase
        if (m_mode == M_RING && nx != M_RING) ring_cycles = m_age + 1;
        if (nx != m_mode || nx == M_IDLE) m_age = 0;
        else m_age++;
        m_mode = nx;
    endtask

    task automatic tick(input string tag);
        bit exp_beep;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        exp_beep = (m_mode == M_RING) && (((m_age / TH) % 2) == 1) && ((m_age % T) < T / 2);
        check({tag, ".ringing"},  ringing,  m_mode == M_RING);
        check({tag, ".snoozing"}, snoozing, m_mode == M_SNOOZE);
        check({tag, ".beep"},     beep,     exp_beep);
    endtask

    task automatic ticks(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    task automatic press(input string tag, input bit stop, input bit snz);
        stop_key = stop; snooze_key = snz;
        tick(tag);
        stop_key = 1'b0; snooze_key = 1'b0;
    endtask

    initial begin
        int ring_start;
        rst = 1'b1; adjust = 2'd0; alarm_en = 1'b1; stop_key = 1'b0; snooze_key = 1'b0;
        apply_time(7, 29, 59);
        apply_alarm(7, 30);
        ticks("reset", 3);
        rst = 1'b0;
        ticks("pre_match", 4);

        // Minute rollover into the alarm minute: two-cycle latency, then a full ring window.
        apply_time(7, 30, 0);
        tick("lat1");
        check("lat1_not_yet", ringing, 1'b0);
        tick("lat2");
        check("lat2_ringing", ringing, 1'b1);
        ticks("ring_full", RS * T + 10);
        check("ring_len_40", ring_cycles == RS * T, 1'b1);
        check("no_retrigger", ringing, 1'b0);

        // Snooze at ring cycle 12, snooze window, re-ring for a full window.
        apply_time(7, 29, 0); ticks("rearm", 3);
        apply_time(7, 30, 0); ticks("ring2", 2);
        ticks("ring2_run", 11);
        press("snooze", 1'b0, 1'b1);
        check("snoozing_now", snoozing, 1'b1);
        ticks("snooze_run", SS * T - 1);
        check("snooze_still", snoozing, 1'b1);
        tick("reringing");
        check("rering", ringing, 1'b1);
        ticks("rering_run", RS * T + 5);
        check("rering_len", ring_cycles == RS * T, 1'b1);

        // Stop and snooze together: stop wins.
        apply_time(7, 29, 0); ticks("rearm", 3);
        apply_time(7, 30, 0); ticks("ring3", 8);
        press("both_keys", 1'b1, 1'b1);
        check("both_idle_r", ringing, 1'b0);
        check("both_idle_s", snoozing, 1'b0);

        // Adjust mode at the match instant suppresses the alarm.
        apply_time(7, 29, 0); ticks("rearm", 3);
        adjust = 2'd1; apply_time(7, 30, 0); ticks("adjust", 5);
        check("adjust_no_ring", ringing, 1'b0);
        apply_time(7, 30, 1); tick("adjust_off"); adjust = 2'd0; ticks("adjust_off", 3);

        // Adjust during snooze does not abort; alarm_en drop does, next cycle.
        apply_time(7, 29, 0); ticks("rearm", 3);
        apply_time(7, 30, 0); ticks("ring4", 5);
        press("snooze2", 1'b0, 1'b1);
        adjust = 2'd2; ticks("snz_adjust", 4);
        check("snz_survives_adjust", snoozing, 1'b1);
        adjust = 2'd0; alarm_en = 1'b0; tick("en_drop");
        check("en_drop_idle", snoozing, 1'b0);
        alarm_en = 1'b1; ticks("en_back", 3);

        // Reset mid-ring with match held: quiet afterwards.
        apply_time(7, 29, 0); ticks("rearm", 3);
        apply_time(7, 30, 0); ticks("ring5", 14);
        rst = 1'b1; tick("mid_rst");
        check("rst_ring", ringing, 1'b0);
        check("rst_beep", beep, 1'b0);
        tick("mid_rst");
        rst = 1'b0; ticks("post_rst", 20);
        check("post_rst_quiet", ringing, 1'b0);

        // Random traffic around the alarm minute.
        apply_alarm(12, 45);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 3))
                    0: apply_time(12, 45, 0);
                    1: apply_time(12, 45, $urandom_range(1, 59));
                    2: apply_time(12, 44, 0);
                    default: apply_time($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
                endcase
            end
            adjust     = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            alarm_en   = ($urandom_range(0, 60) != 0);
            stop_key   = ($urandom_range(0, 60) == 0);
            snooze_key = ($urandom_range(0, 25) == 0);
            rst        = ($urandom_range(0, 300) == 0);
            tick("random");
        end
        rst = 1'b0; stop_key = 1'b0; snooze_key = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
